// File: rtl/prime_pkg.sv
// prime_pkg: state encoding, default sizes and port widths shared by the prime sieve
package prime_pkg;
    localparam int DEF_LIMIT      = 1024;
    localparam int DEF_LIST_DEPTH = 256;
    localparam int IDX_W          = 8;
    localparam int DATA_W         = 10;
    typedef enum logic [2:0] {IDLE, CLEAR, OUTER, MARK, COMPACT, READY} state_t;
endpackage

// File: rtl/prime_list_ram.sv
// prime_list_ram: synchronous single-port prime list with one-cycle read latency
module prime_list_ram
    import prime_pkg::*;
#(
    parameter int DEPTH = DEF_LIST_DEPTH,
    parameter int AW    = 8,
    parameter int DW    = DATA_W
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end
endmodule

// File: rtl/prime_sieve_ctrl.sv
// prime_sieve_ctrl: Eratosthenes sieve over 0..LIMIT-1 that compacts the primes into a readable list
module prime_sieve_ctrl
    import prime_pkg::*;
#(
    parameter int LIMIT      = DEF_LIMIT,
    parameter int LIST_DEPTH = DEF_LIST_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [IDX_W-1:0]  prime_count,
    output logic              overflow,
    input  logic              rd_req,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_ack,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_err
);
    localparam int BW = $clog2(LIMIT);
    localparam int IW = BW + 2;
    localparam int LW = $clog2(LIST_DEPTH);
    localparam int CW = $clog2(LIST_DEPTH + 1) > IDX_W ? $clog2(LIST_DEPTH + 1) : IDX_W + 1;
    localparam logic [IW-1:0]   LIM     = IW'(LIMIT);
    localparam logic [IW-1:0]   LAST    = IW'(LIMIT - 1);
    localparam logic [2*IW-1:0] LIM_SQ  = (2*IW)'(LIMIT);
    localparam logic [CW-1:0]   DEPTH   = CW'(LIST_DEPTH);
    localparam logic [CW-1:0]   CNT_MAX = CW'(2**IDX_W - 1);

    state_t state, state_nx;
    logic [LIMIT-1:0] bits;
    logic [IW-1:0] i, j, k, j_nx;
    logic [2*IW-1:0] sq;
    logic [CW-1:0] cnt;
    logic [LW-1:0] ram_addr;
    logic [DATA_W-1:0] ram_q;
    logic hit, we, rd_hit, rd_bad;

    assign sq          = {{IW{1'b0}}, i} * {{IW{1'b0}}, i};
    assign j_nx        = j + i;
    assign hit         = bits[k[BW-1:0]];
    assign we          = state == COMPACT && hit && cnt < DEPTH;
    assign rd_hit      = state == READY && rd_req && !start;
    assign rd_bad      = rd_idx == '0 || CW'(rd_idx) > cnt;
    assign ram_addr    = we ? cnt[LW-1:0] : LW'(rd_idx - 1'b1);
    assign busy        = state inside {CLEAR, OUTER, MARK, COMPACT};
    assign done        = state == READY;
    assign prime_count = cnt > CNT_MAX ? '1 : cnt[IDX_W-1:0];
    assign rd_data     = rd_ack && !rd_err ? ram_q : '0;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, READY: state_nx = start ? CLEAR : state;
            CLEAR:       state_nx = k == LAST ? OUTER : CLEAR;
            OUTER:       state_nx = sq >= LIM_SQ ? COMPACT : bits[i[BW-1:0]] ? MARK : OUTER;
            MARK:        state_nx = j_nx >= LIM ? OUTER : MARK;
            COMPACT:     state_nx = k == LAST ? READY : COMPACT;
            default:     state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_nx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i        <= '0;
            j        <= '0;
            k        <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
            rd_ack   <= 1'b0;
            rd_err   <= 1'b0;
        end else begin
            rd_ack <= rd_hit;
            rd_err <= rd_hit && rd_bad;
            case (state)
                IDLE, READY: if (start) begin
                    k        <= '0;
                    cnt      <= '0;
                    overflow <= 1'b0;
                end
                CLEAR: begin
                    k <= k + 1'b1;
                    i <= IW'(2);
                end
                OUTER: begin
                    if (sq >= LIM_SQ) k <= IW'(2);
                    else if (bits[i[BW-1:0]]) j <= sq[IW-1:0];
                    else i <= i + 1'b1;
                end
                MARK: begin
                    j <= j_nx;
                    if (j_nx >= LIM) i <= i + 1'b1;
                end
                COMPACT: begin
                    k <= k + 1'b1;
                    if (we) cnt <= cnt + 1'b1;
                    else if (hit) overflow <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Sieve bits are deliberately left out of reset so a reset never disturbs them.
    always_ff @(posedge clk) begin
        if (state == CLEAR) bits[k[BW-1:0]] <= k >= IW'(2);
        else if (state == MARK) bits[j[BW-1:0]] <= 1'b0;
    end

    prime_list_ram #(.DEPTH(LIST_DEPTH), .AW(LW), .DW(DATA_W)) u_list (
        .clk   (clk),
        .we    (we),
        .addr  (ram_addr),
        .wdata (DATA_W'(k)),
        .rdata (ram_q)
    );
endmodule

// File: tb/tb_prime_sieve_ctrl.sv
// tb_prime_sieve_ctrl: scoreboard bench for three sieve configurations against a trial-division model
module tb_prime_sieve_ctrl;
    typedef struct {int d; bit e; longint due;} exp_t;

    logic clk = 1'b0;
    logic reset;
    logic start [3];
    logic rd_req [3];
    logic [7:0] rd_idx [3];
    logic busy [3];
    logic done [3];
    logic overflow [3];
    logic rd_ack [3];
    logic rd_err [3];
    logic [7:0] prime_count [3];
    logic [9:0] rd_data [3];

    exp_t sb [3][$];
    int model [3][$];
    int m_cnt [3];
    bit m_ovf [3];
    longint cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    prime_sieve_ctrl #(.LIMIT(1024), .LIST_DEPTH(256)) u0 (
        .clk(clk), .reset(reset), .start(start[0]), .busy(busy[0]), .done(done[0]),
        .prime_count(prime_count[0]), .overflow(overflow[0]), .rd_req(rd_req[0]),
        .rd_idx(rd_idx[0]), .rd_ack(rd_ack[0]), .rd_data(rd_data[0]), .rd_err(rd_err[0]));
    prime_sieve_ctrl #(.LIMIT(32), .LIST_DEPTH(256)) u1 (
        .clk(clk), .reset(reset), .start(start[1]), .busy(busy[1]), .done(done[1]),
        .prime_count(prime_count[1]), .overflow(overflow[1]), .rd_req(rd_req[1]),
        .rd_idx(rd_idx[1]), .rd_ack(rd_ack[1]), .rd_data(rd_data[1]), .rd_err(rd_err[1]));
    prime_sieve_ctrl #(.LIMIT(1024), .LIST_DEPTH(100)) u2 (
        .clk(clk), .reset(reset), .start(start[2]), .busy(busy[2]), .done(done[2]),
        .prime_count(prime_count[2]), .overflow(overflow[2]), .rd_req(rd_req[2]),
        .rd_idx(rd_idx[2]), .rd_ack(rd_ack[2]), .rd_data(rd_data[2]), .rd_err(rd_err[2]));

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic bit is_prime(input int v);
        if (v < 2) return 1'b0;
        for (int d = 2; d * d <= v; d++) if (v % d == 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic build(input int n, input int lim, input int dep);
        int tot = 0;
        model[n].delete();
        for (int v = 0; v < lim; v++) if (is_prime(v)) begin
            tot++;
            if (model[n].size() < dep) model[n].push_back(v);
        end
        m_cnt[n] = model[n].size();
        m_ovf[n] = tot > dep;
    endtask

    task automatic tick(input int c = 1);
        repeat (c) @(posedge clk);
        #1;
    endtask

    task automatic read(input int n, input int idx);
        exp_t e;
        rd_req[n] = 1'b1;
        rd_idx[n] = 8'(idx);
        e.due = cyc + 1;
        e.e = !(idx >= 1 && idx <= m_cnt[n]);
        e.d = e.e ? 0 : model[n][idx-1];
        sb[n].push_back(e);
        tick();
        rd_req[n] = 1'b0;
    endtask

    task automatic wait_done(input int n, output longint at);
        int c = 0;
        while (!done[n] && c < 20000) begin
            tick();
            c++;
        end
        chk($sformatf("done%0d", n), int'(done[n]), 1);
        at = cyc;
    endtask

    task automatic check_result(input int n);
        chk($sformatf("prime_count%0d", n), int'(prime_count[n]), m_cnt[n]);
        chk($sformatf("overflow%0d", n), int'(overflow[n]), int'(m_ovf[n]));
    endtask

    task automatic check_reset(input int n);
        chk($sformatf("rst_busy%0d", n), int'(busy[n]), 0);
        chk($sformatf("rst_done%0d", n), int'(done[n]), 0);
        chk($sformatf("rst_count%0d", n), int'(prime_count[n]), 0);
        chk($sformatf("rst_ovf%0d", n), int'(overflow[n]), 0);
        chk($sformatf("rst_ack%0d", n), int'(rd_ack[n]), 0);
        chk($sformatf("rst_err%0d", n), int'(rd_err[n]), 0);
        chk($sformatf("rst_data%0d", n), int'(rd_data[n]), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        for (int n = 0; n < 3; n++) begin
            if (rd_ack[n]) begin
                if (sb[n].size() == 0) chk($sformatf("unexpected_ack%0d", n), 1, 0);
                else begin
                    e = sb[n].pop_front();
                    chk($sformatf("ack_latency%0d", n), int'(cyc - e.due), 0);
                    chk($sformatf("rd_data%0d", n), int'(rd_data[n]), e.d);
                    chk($sformatf("rd_err%0d", n), int'(rd_err[n]), int'(e.e));
                end
            end else if (sb[n].size() != 0 && sb[n][0].due <= cyc) begin
                e = sb[n].pop_front();
                chk($sformatf("missing_ack%0d", n), 0, 1);
            end
        end
    end

    initial begin
        longint t0, t1, run0;
        int rn;
        build(0, 1024, 256);
        build(1, 32, 256);
        build(2, 1024, 100);
        reset = 1'b1;
        for (int n = 0; n < 3; n++) begin
            start[n] = 1'b0;
            rd_req[n] = 1'b0;
            rd_idx[n] = '0;
        end
        tick(3);
        for (int n = 0; n < 3; n++) check_reset(n);
        reset = 1'b0;
        tick();

        for (int n = 0; n < 3; n++) start[n] = 1'b1;
        t0 = cyc;
        tick();
        for (int n = 0; n < 3; n++) start[n] = 1'b0;
        for (int n = 0; n < 3; n++) begin
            chk($sformatf("run_busy%0d", n), int'(busy[n]), 1);
            chk($sformatf("run_done%0d", n), int'(done[n]), 0);
        end
        rd_req[0] = 1'b1;
        rd_idx[0] = 8'd1;
        tick(4);
        rd_req[0] = 1'b0;
        run0 = 0;
        for (int n = 0; n < 3; n++) begin
            wait_done(n, t1);
            if (n == 0) run0 = t1 - t0;
        end
        for (int n = 0; n < 3; n++) check_result(n);

        read(0, 1); read(0, 2); read(0, 26); read(0, 172); read(0, 173); read(0, 0);
        read(1, 1); read(1, 11); read(1, 12); read(1, 0);
        read(2, 100); read(2, 101); read(2, 1); read(2, 0);
        for (int x = 1; x <= 5; x++) read(0, x);
        repeat (40) begin
            rn = $urandom_range(0, 2);
            read(rn, $urandom_range(0, m_cnt[rn] + 3));
            if ($urandom_range(0, 1) == 1) tick();
        end
        tick(3);

        start[1] = 1'b1;
        rd_req[1] = 1'b1;
        rd_idx[1] = 8'd1;
        tick();
        start[1] = 1'b0;
        rd_req[1] = 1'b0;
        chk("collide_done", int'(done[1]), 0);
        chk("collide_busy", int'(busy[1]), 1);
        wait_done(1, t1);
        check_result(1);
        read(1, 11);

        start[0] = 1'b1;
        t0 = cyc;
        tick();
        start[0] = 1'b0;
        tick(500);
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        wait_done(0, t1);
        chk("run_length", int'(t1 - t0), int'(run0));
        check_result(0);
        read(0, 172);
        tick(3);

        for (int n = 0; n < 3; n++) start[n] = 1'b1;
        tick();
        for (int n = 0; n < 3; n++) start[n] = 1'b0;
        tick(1100);
        chk("mark_busy0", int'(busy[0]), 1);
        reset = 1'b1;
        #1;
        for (int n = 0; n < 3; n++) check_reset(n);
        tick(2);
        reset = 1'b0;
        tick();
        for (int n = 0; n < 3; n++) start[n] = 1'b1;
        tick();
        for (int n = 0; n < 3; n++) start[n] = 1'b0;
        for (int n = 0; n < 3; n++) wait_done(n, t1);
        for (int n = 0; n < 3; n++) check_result(n);
        read(0, 1); read(0, 2); read(0, 26); read(0, 172);
        read(1, 11); read(1, 12);
        read(2, 100); read(2, 0);
        tick(5);
        for (int n = 0; n < 3; n++) chk($sformatf("drain%0d", n), sb[n].size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/prime_sieve_ctrl.md
PRIME_SIEVE_CTRL -- requirements
Module: prime_sieve_ctrl

Interface
REQ-001 The block SHALL have parameter LIMIT, default 1024, meaning the sieve range 0..LIMIT-1.
REQ-002 The block SHALL have parameter LIST_DEPTH, default 256, meaning the prime-list capacity in entries.
REQ-003 The block SHALL have port clk  input  1  system clock, all logic on the rising edge.
REQ-004 The block SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-005 The block SHALL have port start  input  1  one-cycle pulse that begins a full sieve run.
REQ-006 The block SHALL have port busy  output  1  high while a run is in progress.
REQ-007 The block SHALL have port done  output  1  high while the list is valid and reads are served.
REQ-008 The block SHALL have port prime_count  output  8  number of primes stored in the list.
REQ-009 The block SHALL have port overflow  output  1  set when more primes are found than LIST_DEPTH holds.
REQ-010 The block SHALL have port rd_req  input  1  read request, sampled only when done=1.
REQ-011 The block SHALL have port rd_idx  input  8  1-based prime ordinal to read; prime #1 is 2.
REQ-012 The block SHALL have port rd_ack  output  1  one-cycle pulse returning a read.
REQ-013 The block SHALL have port rd_data  output  10  prime value returned with rd_ack.
REQ-014 The block SHALL have port rd_err  output  1  qualifies rd_ack when rd_idx is out of range.

Function
REQ-015 The FSM SHALL have states IDLE, CLEAR, OUTER, MARK, COMPACT and READY.
REQ-016 In IDLE or READY, start SHALL move the FSM to CLEAR and drop done the following cycle.
REQ-017 In CLEAR, one bit per cycle SHALL be written: bits 0 and 1 to 0 and bits 2..LIMIT-1 to 1. CLEAR SHALL last LIMIT cycles, then go to OUTER with i=2.
REQ-018 In OUTER, if i*i >= LIMIT the FSM SHALL go to COMPACT with k=2.
REQ-019 In OUTER, if bit[i]=1 the FSM SHALL go to MARK with j=i*i.
REQ-020 In OUTER, if bit[i]=0 the FSM SHALL increment i.
REQ-021 In MARK, each cycle SHALL clear bit[j] and set j=j+i. When j+i >= LIMIT the FSM SHALL return to OUTER with i+1.
REQ-022 In COMPACT, each cycle SHALL test bit[k]. If the bit is set and cnt < LIST_DEPTH, list[cnt]=k and cnt SHALL increment. If the bit is set and cnt = LIST_DEPTH, overflow SHALL be set and nothing written. At k = LIMIT-1 the FSM SHALL go to READY.
REQ-023 In READY, done SHALL be 1 and prime_count SHALL equal cnt.
REQ-024 busy SHALL be 1 exactly in CLEAR, OUTER, MARK and COMPACT.
REQ-025 start SHALL be ignored while busy=1.
REQ-026 When rd_req=1 in READY, rd_ack SHALL pulse exactly one cycle later.
REQ-027 On that rd_ack, if 1 <= rd_idx <= prime_count, rd_data SHALL equal list[rd_idx-1] and rd_err SHALL be 0.
REQ-028 On that rd_ack, if rd_idx is outside 1..prime_count, rd_data SHALL be 0 and rd_err SHALL be 1.
REQ-029 Back-to-back rd_req SHALL each be acknowledged; throughput SHALL be one read per cycle.
REQ-030 rd_req outside READY SHALL produce no rd_ack.
REQ-031 If start and rd_req are both high in READY, start SHALL win and no ack SHALL be issued.
REQ-032 i, j and k SHALL be wide enough to hold 2*LIMIT without wrap.
REQ-033 i*i SHALL be compared at full width.

Reset
REQ-034 Asserting reset SHALL, immediately and at any state including mid-run, set state=IDLE, busy=0, done=0, prime_count=0, overflow=0, rd_ack=0, rd_err=0 and rd_data=0.
REQ-035 Reset SHALL NOT clear the sieve bits or the list contents.

Structure
REQ-036 Package prime_pkg SHALL hold the state enum, the default LIMIT/LIST_DEPTH, and the index and data width constants.
REQ-037 The list SHALL be held in sub-module prime_list_ram: synchronous single-port, write in COMPACT, read in READY, one-cycle read latency.
REQ-038 The sieve bit array SHALL be a flat register vector inside prime_sieve_ctrl.

Verification
REQ-039 With LIMIT=1024, after a start pulse: done rises, prime_count=172, overflow=0. Reads SHALL return rd_idx=1->2, 2->3, 26->101, 172->1021.
REQ-040 With LIMIT=32, after start: prime_count=11. Reads SHALL return 1->2, 11->31, 12->rd_err=1 with rd_data=0.
REQ-041 With rd_idx=0 in READY: rd_ack SHALL pulse with rd_err=1.
REQ-042 With rd_req held for 5 cycles on indices 1..5: five consecutive acks SHALL return 2, 3, 5, 7, 11.
REQ-043 With reset asserted in MARK, released, then start: the result SHALL be identical to REQ-039. A start during busy SHALL not extend the run.
REQ-044 With LIMIT=1024 and LIST_DEPTH=100: prime_count=100, overflow=1, and rd_idx=100 SHALL return 541.
